dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Control FSM for the 2-way set-associative write-back data cache.
- Sits directly upstream of the per-way tag/valid/dirty/LRU register arrays. It drives their shared read/write index and load strobes, and consumes their registered outputs one cycle later.
- Also sequences CPU hit responses and physical-memory writeback/fill bursts (one 256-bit line per transfer; line datapath external).

Parameters:
- s_index, 3, set-index bits. Offset fixed at 5 bits; s_tag = 27 - s_index (localparam).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  32  CPU address, stable while request held
- mem_resp  out  1  one-cycle completion pulse
- arr_index  out  s_index  rindex/windex to all arrays = mem_address[5+s_index-1:5]
- tag_out0, tag_out1  in  s_tag  registered tag array outputs
- valid_out0, valid_out1, dirty_out0, dirty_out1  in  1 each  registered status outputs
- lru_out  in  1  registered LRU bit; value = victim way
- tag_load0, tag_load1, valid_load0, valid_load1, dirty_load0, dirty_load1  out  1 each  array write strobes
- dirty_in  out  1  dirty value written
- lru_load  out  1  LRU write strobe
- lru_in  out  1  LRU value written
- data_load0, data_load1  out  1 each  data array write strobes
- data_src  out  1  0 = CPU write data, 1 = pmem fill line
- out_way  out  1  way muxed to CPU read data / pmem write data
- pmem_read, pmem_write  out  1 each  memory requests, held until pmem_resp
- pmem_address  out  32  line-aligned memory address
- pmem_resp  in  1  memory done

Behaviour:
- Arrays have 1-cycle registered read with load-bypass. arr_index is combinational from mem_address at all times.
- Tag array datain is mem_address tag. Valid datain is 1.
- States:
  - IDLE: all strobes 0. On mem_read|mem_write, go to LOOKUP.
  - LOOKUP: hit_w = valid_out_w & (tag_out_w == tag). Hit on both ways is illegal; way 0 wins.
    - On hit: mem_resp=1, out_way=hit way, lru_load=1, lru_in=~hit way.
    - On hit with write: additionally data_load[hit]=1, data_src=0, dirty_load[hit]=1, dirty_in=1.
    - After a hit, next state is IDLE.
    - On miss: latch victim=lru_out and victim_tag. Next state is WRITEBACK if the victim is valid&dirty, else FILL.
  - WRITEBACK: pmem_write=1, pmem_address={victim_tag,index,5'b0}, out_way=victim. On pmem_resp, go to FILL.
  - FILL: pmem_read=1, pmem_address={tag,index,5'b0}. On pmem_resp, in the same cycle:
    - data_load[victim]=1, data_src=1
    - tag_load[victim]=1, valid_load[victim]=1
    - dirty_load[victim]=1, dirty_in=0
    - next state is LOOKUP, which now hits via bypass.
- Latency:
  - Hit: mem_resp in the 2nd cycle after the request is first seen in IDLE.
  - Clean miss: LOOKUP, FILL until pmem_resp, then LOOKUP.
- mem_read & mem_write together is treated as a write.
- A request deasserted before mem_resp is a protocol violation (unchecked).
- Reset (async, any state): state=IDLE, victim=0, victim_tag=0.
  - mem_resp, pmem_read, pmem_write and all strobes go low immediately.
  - pmem_address=0, out_way=0, data_src=0.
  - In-flight transaction is abandoned.
- All outputs are decoded from state and registers only; no output depends on pmem_resp except the FILL/WRITEBACK exit strobes.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each LOOKUP hit that is not the retry following a FILL.
  - miss_count increments on each LOOKUP miss.
  - Both saturate at 0xFFFFFFFF and clear on rst_n.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset with arrays all zero; read 0x0000_1040 (s_index=3, set 2) -> LOOKUP miss, FILL with pmem_address=0x0000_1040. On pmem_resp: tag_load0=valid_load0=data_load0=1, dirty_in=0. Next cycle LOOKUP hit, mem_resp=1, lru_in=1.
- Repeat read 0x0000_1044 -> mem_resp 2 cycles after request, no pmem_read/pmem_write, out_way=0.
- Write 0x0000_1048 -> hit way0, data_load0=1, data_src=0, dirty_load0=1, dirty_in=1, mem_resp same cycle.
- Fill way1 with 0x0000_2040 (dirty way0 is then victim); access 0x0000_3040 -> pmem_write with pmem_address=0x0000_1040, then pmem_read 0x0000_3040, fill way0, mem_resp.
- Assert rst_n=0 mid-FILL with pmem_read high -> pmem_read low with no clock edge; after release, FSM is in IDLE with no strobes.
- With DCACHE_PERF_CNT_EN defined, run the sequence above -> hit_count=2, miss_count=3.

Source files
------------

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Control FSM for a 2-way set-associative write-back data cache.
//            Optional hit/miss counters are enabled by DCACHE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int s_index = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         mem_address,
    output logic                mem_resp,
    output logic [s_index-1:0]  arr_index,
    input  logic [27-s_index-1:0] tag_out0,
    input  logic [27-s_index-1:0] tag_out1,
    input  logic                valid_out0,
    input  logic                valid_out1,
    input  logic                dirty_out0,
    input  logic                dirty_out1,
    input  logic                lru_out,
    output logic                tag_load0,
    output logic                tag_load1,
    output logic                valid_load0,
    output logic                valid_load1,
    output logic                dirty_load0,
    output logic                dirty_load1,
    output logic                dirty_in,
    output logic                lru_load,
    output logic                lru_in,
    output logic                data_load0,
    output logic                data_load1,
    output logic                data_src,
    output logic                out_way,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [31:0]         pmem_address,
    input  logic                pmem_resp
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    localparam int s_tag = 27 - s_index;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_FILL      = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_victim;
    logic [s_tag-1:0]   r_victim_tag;

    logic [s_tag-1:0]   w_tag;
    logic [s_index-1:0] w_index;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic               w_hit_way;
    logic               w_victim_dirty;
    logic               w_unused_offset;

    assign w_tag           = mem_address[31 -: s_tag];
    assign w_index         = mem_address[5 +: s_index];
    assign arr_index       = w_index;
    assign w_unused_offset = ^mem_address[4:0];

    assign w_hit0    = valid_out0 & (tag_out0 == w_tag);
    assign w_hit1    = valid_out1 & (tag_out1 == w_tag);
    assign w_hit     = w_hit0 | w_hit1;
    // Way 0 takes priority if both ways ever match.
    assign w_hit_way = ~w_hit0;

    assign w_victim_dirty = lru_out ? (valid_out1 & dirty_out1)
                                    : (valid_out0 & dirty_out0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_victim     <= 1'b0;
            r_victim_tag <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_read | mem_write)
                        r_state <= ST_LOOKUP;
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_victim     <= lru_out;
                        r_victim_tag <= lru_out ? tag_out1 : tag_out0;
                        r_state      <= w_victim_dirty ? ST_WRITEBACK : ST_FILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (pmem_resp)
                        r_state <= ST_FILL;
                end
                ST_FILL: begin
                    // Return to LOOKUP; the array bypass makes the retry hit.
                    if (pmem_resp)
                        r_state <= ST_LOOKUP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_resp     = 1'b0;
        tag_load0    = 1'b0;
        tag_load1    = 1'b0;
        valid_load0  = 1'b0;
        valid_load1  = 1'b0;
        dirty_load0  = 1'b0;
        dirty_load1  = 1'b0;
        dirty_in     = 1'b0;
        lru_load     = 1'b0;
        lru_in       = 1'b0;
        data_load0   = 1'b0;
        data_load1   = 1'b0;
        data_src     = 1'b0;
        out_way      = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'h0;
        case (r_state)
            ST_LOOKUP: begin
                if (w_hit) begin
                    mem_resp = 1'b1;
                    out_way  = w_hit_way;
                    lru_load = 1'b1;
                    lru_in   = ~w_hit_way;
                    if (mem_write) begin
                        data_load0  = ~w_hit_way;
                        data_load1  = w_hit_way;
                        dirty_load0 = ~w_hit_way;
                        dirty_load1 = w_hit_way;
                        dirty_in    = 1'b1;
                    end
                end
            end
            ST_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_victim_tag, w_index, 5'b0};
                out_way      = r_victim;
            end
            ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_index, 5'b0};
                if (pmem_resp) begin
                    data_src    = 1'b1;
                    data_load0  = ~r_victim;
                    data_load1  = r_victim;
                    tag_load0   = ~r_victim;
                    tag_load1   = r_victim;
                    valid_load0 = ~r_victim;
                    valid_load1 = r_victim;
                    dirty_load0 = ~r_victim;
                    dirty_load1 = r_victim;
                end
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        r_retry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
            r_retry      <= 1'b0;
        end else begin
            if (r_state == ST_FILL && pmem_resp)
                r_retry <= 1'b1;
            else if (r_state == ST_LOOKUP)
                r_retry <= 1'b0;
            if (r_state == ST_LOOKUP) begin
                if (w_hit && !r_retry && r_hit_count != 32'hFFFF_FFFF)
                    r_hit_count <= r_hit_count + 32'd1;
                if (!w_hit && r_miss_count != 32'hFFFF_FFFF)
                    r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Directed bench for dcache_ctrl with a behavioural tag/status array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    localparam int c_si = 3;
    localparam int c_st = 27 - c_si;

    logic            clk;
    logic            rst_n;
    logic            mem_read;
    logic            mem_write;
    logic [31:0]     mem_address;
    logic            mem_resp;
    logic [c_si-1:0] arr_index;
    logic [c_st-1:0] tag_out0, tag_out1;
    logic            valid_out0, valid_out1, dirty_out0, dirty_out1, lru_out;
    logic            tag_load0, tag_load1, valid_load0, valid_load1;
    logic            dirty_load0, dirty_load1, dirty_in, lru_load, lru_in;
    logic            data_load0, data_load1, data_src, out_way;
    logic            pmem_read, pmem_write, pmem_resp;
    logic [31:0]     pmem_address;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]     hit_count, miss_count;
`endif

    logic            model_clr;
    int              n_vec = 0;
    int              n_err = 0;

    dcache_ctrl #(.s_index(c_si)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_resp(mem_resp), .arr_index(arr_index),
        .tag_out0(tag_out0), .tag_out1(tag_out1),
        .valid_out0(valid_out0), .valid_out1(valid_out1),
        .dirty_out0(dirty_out0), .dirty_out1(dirty_out1), .lru_out(lru_out),
        .tag_load0(tag_load0), .tag_load1(tag_load1),
        .valid_load0(valid_load0), .valid_load1(valid_load1),
        .dirty_load0(dirty_load0), .dirty_load1(dirty_load1), .dirty_in(dirty_in),
        .lru_load(lru_load), .lru_in(lru_in),
        .data_load0(data_load0), .data_load1(data_load1), .data_src(data_src),
        .out_way(out_way), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_resp(pmem_resp)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read arrays with write bypass, as the real arrays behave.
    logic [c_st-1:0] m_tag   [2][8];
    logic            m_valid [2][8];
    logic            m_dirty [2][8];
    logic            m_lru   [8];

    always @(posedge clk) begin
        if (model_clr) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 8; s++) begin
                    m_tag[w][s]   <= '0;
                    m_valid[w][s] <= 1'b0;
                    m_dirty[w][s] <= 1'b0;
                end
            for (int s = 0; s < 8; s++) m_lru[s] <= 1'b0;
            tag_out0 <= '0; tag_out1 <= '0;
            valid_out0 <= 1'b0; valid_out1 <= 1'b0;
            dirty_out0 <= 1'b0; dirty_out1 <= 1'b0;
            lru_out <= 1'b0;
        end else begin
            tag_out0   <= tag_load0   ? mem_address[31:8] : m_tag[0][arr_index];
            tag_out1   <= tag_load1   ? mem_address[31:8] : m_tag[1][arr_index];
            valid_out0 <= valid_load0 ? 1'b1 : m_valid[0][arr_index];
            valid_out1 <= valid_load1 ? 1'b1 : m_valid[1][arr_index];
            dirty_out0 <= dirty_load0 ? dirty_in : m_dirty[0][arr_index];
            dirty_out1 <= dirty_load1 ? dirty_in : m_dirty[1][arr_index];
            lru_out    <= lru_load    ? lru_in : m_lru[arr_index];
            if (tag_load0)   m_tag[0][arr_index]   <= mem_address[31:8];
            if (tag_load1)   m_tag[1][arr_index]   <= mem_address[31:8];
            if (valid_load0) m_valid[0][arr_index] <= 1'b1;
            if (valid_load1) m_valid[1][arr_index] <= 1'b1;
            if (dirty_load0) m_dirty[0][arr_index] <= dirty_in;
            if (dirty_load1) m_dirty[1][arr_index] <= dirty_in;
            if (lru_load)    m_lru[arr_index]      <= lru_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = 32'h0; pmem_resp = 1'b0; model_clr = 1'b1;
        step(); step();
        check("rst_mem_resp",  32'(mem_resp), 0);
        check("rst_pmem_read", 32'(pmem_read), 0);
        check("rst_pmem_wr",   32'(pmem_write), 0);
        check("rst_pmem_addr", pmem_address, 32'h0);
        model_clr = 1'b0; rst_n = 1'b1;
        step();

        // Cold read miss on set 2, clean fill into way 0
        mem_read = 1'b1; mem_address = 32'h0000_1040; #1;
        check("t1_index", 32'(arr_index), 2);
        check("t1_idle_resp", 32'(mem_resp), 0);
        step();
        check("t1_miss_resp", 32'(mem_resp), 0);
        step();
        check("t1_fill_rd",   32'(pmem_read), 1);
        check("t1_fill_wr",   32'(pmem_write), 0);
        check("t1_fill_addr", pmem_address, 32'h0000_1040);
        check("t1_fill_noload", 32'(tag_load0), 0);
        pmem_resp = 1'b1; #1;
        check("t1_tag_load0",   32'(tag_load0), 1);
        check("t1_valid_load0", 32'(valid_load0), 1);
        check("t1_data_load0",  32'(data_load0), 1);
        check("t1_dirty_load0", 32'(dirty_load0), 1);
        check("t1_dirty_in",    32'(dirty_in), 0);
        check("t1_data_src",    32'(data_src), 1);
        check("t1_tag_load1",   32'(tag_load1), 0);
        step(); pmem_resp = 1'b0; #1;
        check("t1_retry_resp", 32'(mem_resp), 1);
        check("t1_lru_load",   32'(lru_load), 1);
        check("t1_lru_in",     32'(lru_in), 1);
        check("t1_out_way",    32'(out_way), 0);
        check("t1_retry_prd",  32'(pmem_read), 0);
        step(); mem_read = 1'b0; #1;
        check("t1_idle_after", 32'(mem_resp), 0);

        // Read hit: response in second cycle
        mem_read = 1'b1; mem_address = 32'h0000_1044; #1;
        check("t2_c1_resp", 32'(mem_resp), 0);
        step();
        check("t2_c2_resp",  32'(mem_resp), 1);
        check("t2_out_way",  32'(out_way), 0);
        check("t2_pmem_rd",  32'(pmem_read), 0);
        check("t2_pmem_wr",  32'(pmem_write), 0);
        check("t2_no_dload", 32'(data_load0), 0);
        step(); mem_read = 1'b0;

        // Write hit on way 0
        mem_write = 1'b1; mem_address = 32'h0000_1048;
        step();
        check("t3_resp",        32'(mem_resp), 1);
        check("t3_data_load0",  32'(data_load0), 1);
        check("t3_data_load1",  32'(data_load1), 0);
        check("t3_data_src",    32'(data_src), 0);
        check("t3_dirty_load0", 32'(dirty_load0), 1);
        check("t3_dirty_in",    32'(dirty_in), 1);
        step(); mem_write = 1'b0;

        // Miss into invalid way 1 (LRU points at it), no writeback
        mem_read = 1'b1; mem_address = 32'h0000_2040;
        step();
        check("t4_miss_resp", 32'(mem_resp), 0);
        step();
        check("t4_pmem_wr",   32'(pmem_write), 0);
        check("t4_pmem_rd",   32'(pmem_read), 1);
        check("t4_fill_addr", pmem_address, 32'h0000_2040);
        pmem_resp = 1'b1; #1;
        check("t4_tag_load1", 32'(tag_load1), 1);
        check("t4_tag_load0", 32'(tag_load0), 0);
        step(); pmem_resp = 1'b0; #1;
        check("t4_resp",    32'(mem_resp), 1);
        check("t4_out_way", 32'(out_way), 1);
        check("t4_lru_in",  32'(lru_in), 0);
        step(); mem_read = 1'b0;

        // Conflict miss evicting dirty way 0
        mem_read = 1'b1; mem_address = 32'h0000_3040;
        step();
        check("t5_miss_resp", 32'(mem_resp), 0);
        step();
        check("t5_wb_wr",   32'(pmem_write), 1);
        check("t5_wb_rd",   32'(pmem_read), 0);
        check("t5_wb_addr", pmem_address, 32'h0000_1040);
        check("t5_wb_way",  32'(out_way), 0);
        step();
        check("t5_wb_hold", 32'(pmem_write), 1);
        pmem_resp = 1'b1;
        step(); pmem_resp = 1'b0; #1;
        check("t5_fill_rd",   32'(pmem_read), 1);
        check("t5_fill_wr",   32'(pmem_write), 0);
        check("t5_fill_addr", pmem_address, 32'h0000_3040);
        pmem_resp = 1'b1; #1;
        check("t5_tag_load0",   32'(tag_load0), 1);
        check("t5_dirty_load0", 32'(dirty_load0), 1);
        check("t5_dirty_in",    32'(dirty_in), 0);
        step(); pmem_resp = 1'b0; #1;
        check("t5_resp",    32'(mem_resp), 1);
        check("t5_out_way", 32'(out_way), 0);
        step(); mem_read = 1'b0;

`ifdef DCACHE_PERF_CNT_EN
        check("perf_hits",   hit_count, 32'd2);
        check("perf_misses", miss_count, 32'd3);
`endif

        // Asynchronous reset in the middle of a fill
        mem_read = 1'b1; mem_address = 32'h0000_5040;
        step(); step();
        check("t6_fill_rd", 32'(pmem_read), 1);
        rst_n = 1'b0; #1;
        check("t6_rst_prd",  32'(pmem_read), 0);
        check("t6_rst_addr", pmem_address, 32'h0);
        check("t6_rst_way",  32'(out_way), 0);
        check("t6_rst_resp", 32'(mem_resp), 0);
        mem_read = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        check("t6_idle_prd",  32'(pmem_read), 0);
        check("t6_idle_pwr",  32'(pmem_write), 0);
        check("t6_idle_tld",  32'(tag_load0), 0);
        check("t6_idle_lru",  32'(lru_load), 0);
        mem_read = 1'b1; mem_address = 32'h0000_3044; #1;
        check("t6_post_c1", 32'(mem_resp), 0);
        step();
        check("t6_post_hit", 32'(mem_resp), 1);
        step(); mem_read = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
